// File: rtl/product_accumulator.sv
// product_accumulator
//   Sums a block of LEN unsigned products from an upstream multiplier and
//   presents the block sum with a valid/ready handshake.
//
//   Parameters
//     N      product width (upstream multiplier output width)
//     ACC_W  accumulator / sum width, ACC_W > N
//     LEN    products per block, 2..256
//
//   Ports
//     clk        single clock, rising edge
//     rst        synchronous, active-high reset
//     start      one-cycle pulse opening a new block (restarts an open block)
//     p_valid    P carries a valid product this cycle
//     P          unsigned product, zero-extended into the accumulator
//     sum_ready  downstream accepts sum_out
//     sum_out    registered block sum (wraps modulo 2^ACC_W)
//     sum_valid  sum_out holds a completed block
//     busy       registered, high while a block is open or its sum is pending
//     overflow   sticky: some addition in the block carried out of ACC_W bits
//     drop       sticky: a product arrived while the sum was waiting
module product_accumulator #(
    parameter int N     = 16,
    parameter int ACC_W = 24,
    parameter int LEN   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             p_valid,
    input  logic [N-1:0]     P,
    input  logic             sum_ready,
    output logic [ACC_W-1:0] sum_out,
    output logic             sum_valid,
    output logic             busy,
    output logic             overflow,
    output logic             drop
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    // One extra bit so the carry out of the ACC_W-bit add is visible.
    logic [ACC_W:0]   add;
    assign add = {1'b0, acc} + (ACC_W + 1)'(P);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            drop      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Products outside a block are ignored.
                    if (start) begin
                        state    <= ACCUM;
                        busy     <= 1'b1;
                        acc      <= '0;
                        cnt      <= '0;
                        overflow <= 1'b0;
                        drop     <= 1'b0;
                    end
                end

                ACCUM: begin
                    if (start) begin
                        // Restart wins; a product in the same cycle is discarded.
                        acc      <= '0;
                        cnt      <= '0;
                        overflow <= 1'b0;
                        drop     <= 1'b0;
                    end else if (p_valid) begin
                        overflow <= overflow | add[ACC_W];
                        if (cnt == LAST) begin
                            sum_out   <= add[ACC_W-1:0];
                            sum_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            acc <= add[ACC_W-1:0];
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                HOLD: begin
                    if (p_valid)
                        drop <= 1'b1;
                    if (sum_ready) begin
                        sum_valid <= 1'b0;
                        if (start) begin
                            // Back-to-back block: accumulate from the next cycle.
                            state    <= ACCUM;
                            acc      <= '0;
                            cnt      <= '0;
                            overflow <= 1'b0;
                            drop     <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    // start without sum_ready is ignored: the pending sum stays.
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

    localparam int N   = 16;
    localparam int LEN = 4;
    localparam int AW  = 24;
    localparam int AWS = 17;

    logic          clk = 1'b0;
    logic          rst, start, p_valid, sum_ready;
    logic [N-1:0]  P;

    logic [AW-1:0]  sum_out;
    logic           sum_valid, busy, overflow, drop;
    logic [AWS-1:0] s_sum_out;
    logic           s_sum_valid, s_busy, s_overflow, s_drop;

    always #5 clk = ~clk;

    product_accumulator #(.N(N), .ACC_W(AW), .LEN(LEN)) dut (
        .clk(clk), .rst(rst), .start(start), .p_valid(p_valid), .P(P),
        .sum_ready(sum_ready), .sum_out(sum_out), .sum_valid(sum_valid),
        .busy(busy), .overflow(overflow), .drop(drop)
    );

    // Narrow accumulator driven by the same stimulus, to exercise wrap/overflow.
    product_accumulator #(.N(N), .ACC_W(AWS), .LEN(LEN)) dut_s (
        .clk(clk), .rst(rst), .start(start), .p_valid(p_valid), .P(P),
        .sum_ready(sum_ready), .sum_out(s_sum_out), .sum_valid(s_sum_valid),
        .busy(s_busy), .overflow(s_overflow), .drop(s_drop)
    );

    typedef struct {
        longint sum;
        bit     ovf;
        longint ssum;
        bit     sovf;
        bit     drp;
    } exp_t;

    exp_t   q[$];
    longint cur[$];
    int     errors = 0;
    int     checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: block sum is the plain arithmetic total; it wraps modulo
    // 2^W and overflow is set exactly when the true total does not fit.
    function automatic exp_t model(input longint prods[$], input bit drp);
        longint t = 0;
        exp_t   e;
        foreach (prods[i]) t += prods[i];
        e.sum  = t % (longint'(1) << AW);
        e.ovf  = (t >= (longint'(1) << AW));
        e.ssum = t % (longint'(1) << AWS);
        e.sovf = (t >= (longint'(1) << AWS));
        e.drp  = drp;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        cur.delete();
    endtask

    task automatic give(input longint v, input int gap, input bit drp);
        repeat (gap) step();
        p_valid = 1'b1;
        P       = N'(v);
        cur.push_back(v);
        if (cur.size() == LEN) begin
            q.push_back(model(cur, drp));
            cur.delete();
        end
        step();
        p_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sum_out"},   sum_out,   0);
        chk({tag, "_sum_valid"}, sum_valid, 0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_overflow"},  overflow,  0);
        chk({tag, "_drop"},      drop,      0);
        chk({tag, "_s_sum_out"}, s_sum_out, 0);
    endtask

    // Monitor: pops an expectation on every accepted sum and checks that a
    // sum waiting on backpressure does not move.
    logic [AW-1:0] prev_sum;
    logic          prev_hold = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_stable", sum_out, prev_sum);
                chk("hold_valid", sum_valid, 1);
            end
            if (sum_valid || s_sum_valid)
                chk("valid_agree", s_sum_valid, sum_valid);
            if (sum_valid && sum_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sum: got sum_out=%0d expected no sum", sum_out);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sum_out",    sum_out,    e.sum);
                    chk("overflow",   overflow,   e.ovf);
                    chk("s_sum_out",  s_sum_out,  e.ssum);
                    chk("s_overflow", s_overflow, e.sovf);
                    chk("drop",       drop,       e.drp);
                    chk("s_drop",     s_drop,     e.drp);
                end
            end
            prev_hold <= sum_valid && !sum_ready;
            prev_sum  <= sum_out;
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; p_valid = 1'b0; P = '0; sum_ready = 1'b0;
        step();
        // Reset wins over other inputs.
        start = 1'b1; p_valid = 1'b1; P = 16'd5; sum_ready = 1'b1;
        step();
        start = 1'b0; p_valid = 1'b0; sum_ready = 1'b0;
        check_zero("reset");
        rst = 1'b0;
        step();

        // Basic block
        sum_ready = 1'b1;
        do_start();
        chk("basic_busy", busy, 1);
        give(100, 0, 0);
        give(200, 0, 0);
        give(300, 0, 0);
        give(400, 0, 0);
        chk("basic_valid", sum_valid, 1);
        chk("basic_sum", sum_out, 1000);
        step();
        chk("basic_valid_1cyc", sum_valid, 0);
        chk("basic_idle", busy, 0);

        // Gapped input with backpressure; start while holding is ignored.
        sum_ready = 1'b0;
        do_start();
        for (int i = 0; i < LEN; i++) give(65025, $urandom_range(0, 3), 0);
        chk("bp_overflow", overflow, 0);
        chk("bp_s_overflow", s_overflow, 1);
        chk("bp_s_sum", s_sum_out, 260100 % 131072);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", sum_valid, 1);
            chk("bp_sum", sum_out, 260100);
            start = (i == 2);
            step();
        end
        start = 1'b0;
        chk("bp_busy", busy, 1);
        sum_ready = 1'b1;
        step();
        chk("bp_released", sum_valid, 0);
        chk("bp_idle", busy, 0);

        // Restart and drop
        sum_ready = 1'b0;
        do_start();
        give(7, 0, 0);
        give(8, 1, 0);
        start = 1'b1; p_valid = 1'b1; P = 16'd50;
        step();
        start = 1'b0; p_valid = 1'b0;
        cur.delete();
        give(1, 0, 1);
        give(2, 0, 1);
        give(3, 0, 1);
        give(4, 0, 1);
        chk("rs_sum", sum_out, 10);
        chk("rs_drop_clear", drop, 0);
        p_valid = 1'b1; P = 16'd9;
        step();
        p_valid = 1'b0;
        chk("rs_drop", drop, 1);
        chk("rs_sum_kept", sum_out, 10);
        sum_ready = 1'b1;
        step();
        chk("rs_released", sum_valid, 0);
        chk("rs_drop_sticky", drop, 1);

        // Reset mid-block
        do_start();
        give(5, 0, 0);
        give(6, 0, 0);
        give(7, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cur.delete();
        check_zero("mid_reset");
        p_valid = 1'b1; P = 16'd8;
        step();
        p_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mr_no_valid", sum_valid, 0);
            step();
        end
        do_start();
        give(11, 0, 0);
        give(22, 0, 0);
        give(33, 0, 0);
        give(44, 0, 0);
        chk("mr_sum", sum_out, 110);
        step();

        // Back-to-back random 8x8 product blocks
        sum_ready = 1'b0;
        do_start();
        for (int b = 0; b < 10; b++) begin
            for (int i = 0; i < LEN; i++) begin
                longint a, c;
                a = $urandom_range(0, 255);
                c = $urandom_range(0, 255);
                give(a * c, (i == 0) ? 0 : $urandom_range(0, 2), 0);
            end
            repeat ($urandom_range(0, 2)) step();
            sum_ready = 1'b1;
            if (b < 9) begin
                start = 1'b1;
                step();
                start = 1'b0;
                cur.delete();
                chk("b2b_busy", busy, 1);
                chk("b2b_valid_low", sum_valid, 0);
            end else begin
                step();
            end
            sum_ready = 1'b0;
        end

        repeat (3) step();
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
